cg_seq_ctrl: RTL and testbench
==============================

// Module: cg_seq_ctrl
// PURPOSE
//   Sequencer and clock-gate controller for the 6-word, 9-bit, mode-driven datapath.
//   - Accepts a 6-cycle in_valid burst.
//   - Steps the datapath through up to 3 mode-selected compute stages.
//   - Streams 6 result words out.
//   - Drives the per-region clock-gate enables, overridden to always-on when cg_en=0.
//   - Sits between the top-level handshake pins and the datapath register banks.
// PARAMETERS
//   N_WORDS    6  words per burst, both in and out
//   N_STAGES   3  compute stages; in_mode bit k enables stage k
//   STAGE_CYC  2  cycles spent in each enabled stage (>=1)
// PORTS
//   clk            in   1  system clock
//   rst            in   1  asynchronous reset, active-high
//   cg_en          in   1  1 = clock gating active; 0 = every gclk_en_* forced to 1
//   in_valid       in   1  input burst valid
//   in_mode        in   3  stage-enable mask; sampled on the first in_valid cycle only
//   load_en        out  1  datapath writes in_data into word wr_idx
//   wr_idx         out  3  input word index, 0..N_WORDS-1
//   stage_en       out  3  one-hot, active compute stage
//   stage_first    out  1  first cycle of the current stage
//   rd_idx         out  3  output word index, 0..N_WORDS-1
//   out_valid      out  1  out_data (word rd_idx) is valid
//   gclk_en_load   out  1  clock enable for the input register bank
//   gclk_en_calc   out  3  clock enable per stage register bank
//   gclk_en_out    out  1  clock enable for the output register
//   busy           out  1  state != IDLE
//   err            out  1  one-cycle pulse on protocol violation
// BEHAVIOUR
//   Reset (async, any time, including mid-burst):
//     - state=IDLE; every output 0 except gclk_en_*, which equal ~cg_en.
//     - mode_q=0.
//   States: IDLE, LOAD, CALC, OUT.
//   IDLE:
//     - in_valid=1: capture mode_q<=in_mode; load_en=1, wr_idx=0; go to LOAD with wr_idx=1 next.
//   LOAD:
//     - Each in_valid cycle: load_en=1, wr_idx increments.
//     - Cycle with wr_idx=N_WORDS-1 accepted: go to CALC.
//     - If mode_q==0: go to OUT directly, skipping CALC.
//     - in_valid=0 before word N_WORDS-1: err pulse, go to IDLE. Partial data discarded.
//   CALC:
//     - Stages visited in order 0,1,2; stages with mode_q[k]=0 take zero cycles.
//     - Each enabled stage holds stage_en=1<<k for STAGE_CYC cycles.
//     - stage_first=1 on that stage's first cycle.
//     - After the last enabled stage: go to OUT.
//   OUT:
//     - out_valid=1 for exactly N_WORDS consecutive cycles; rd_idx counts 0..N_WORDS-1.
//     - Then go to IDLE; out_valid=0 and rd_idx=0 in IDLE.
//   Latency:
//     - Counted from the clock edge accepting word 5 to the first out_valid cycle.
//     - Equals 1 + STAGE_CYC*popcount(mode_q).
//     - Example: mode 000 -> 1 cycle; mode 111 with STAGE_CYC=2 -> 7 cycles.
//   in_valid=1 during CALC or OUT:
//     - Ignored; err pulse once per offending cycle; sequence unaffected.
//   in_valid=1 during the cycle after OUT ends (state IDLE):
//     - Accepted normally as a new burst; no bubble is required.
//   Clock-gate enables:
//     - Combinational from registered state plus in_valid; glitch-free into latch-based ICGs.
//     - gclk_en_load = (IDLE & in_valid) | LOAD.
//     - gclk_en_calc[k] = stage_en[k] | (LOAD & last word & mode_q-first-stage==k); opens 1 cycle early for setup.
//     - gclk_en_out = (CALC last cycle) | OUT | (LOAD last word & mode_q==0).
//     - With cg_en=0, all gclk_en_* = 1; sequencing outputs are unaffected.
//   Widths:
//     - Counters are 3 bits and saturate at N_WORDS-1 / STAGE_CYC-1; they never wrap into invalid indices.
// STRUCTURE
//   Package cg_seq_pkg:
//     - State enum (IDLE, LOAD, CALC, OUT).
//     - N_WORDS, N_STAGES, IDX_W=3, STAGE_CYC default.
//     - Function next_stage(mode_q, cur) returning the next enabled stage index or "none".
//   Sub-module cg_seq_cnt:
//     - Loadable, clearable, terminal-count-flagging counter.
//     - Instantiated for wr_idx/rd_idx (shared; the two counts never overlap) and for the stage cycle count.
//   The FSM and gate-enable decode live in cg_seq_ctrl.
// TESTING
//   1. Reset mid-LOAD (assert rst after word 3) -> all outputs 0 that cycle; busy=0; next burst completes normally.
//   2. mode=000, 6-word burst -> out_valid high exactly 1 cycle after word 5, for 6 cycles; rd_idx 0..5; stage_en never set.
//   3. mode=101, STAGE_CYC=2 -> stage_en=001 x2, then 100 x2; first out_valid 5 cycles after word 5.
//   4. cg_en=0 for the whole burst -> every gclk_en_* stays 1; out_valid timing identical to the cg_en=1 run.
//   5. in_valid drops after word 2 -> err pulse; return to IDLE; no out_valid; next full burst is correct.
//   6. 1000 back-to-back bursts, random mode, 2 idle cycles between -> latency always 1+2*popcount(mode); err never set.

Source files
------------

// File: rtl/cg_seq_pkg.sv
// Shared types, sizes and the stage-walk helper for the clock-gated sequencer.
package cg_seq_pkg;

  localparam int N_WORDS       = 6;
  localparam int N_STAGES      = 3;
  localparam int IDX_W         = 3;
  localparam int STAGE_CYC_DEF = 2;

  localparam logic [IDX_W-1:0] STAGE_NONE = IDX_W'(N_STAGES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  // Lowest enabled stage at or above 'start', or STAGE_NONE when nothing remains.
  function automatic logic [IDX_W-1:0] next_stage(input logic [N_STAGES-1:0] mode,
                                                  input logic [IDX_W-1:0]    start);
    logic [IDX_W-1:0] result;
    result = STAGE_NONE;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (k >= int'(start) && mode[k]) begin
        result = IDX_W'(k);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cg_seq_cnt.sv
// Small saturating index counter with clear, load and terminal-count flag.
module cg_seq_cnt
  import cg_seq_pkg::*;
#(
  parameter logic [IDX_W-1:0] MAX = IDX_W'(N_WORDS - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             inc,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  assign tc = (count == MAX);

  // Clear wins over load, load over increment; the count never passes MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
    end else if (inc && (count < MAX)) begin
      count <= count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cg_seq_ctrl.sv
// Burst sequencer for the 6-word datapath: load, mode-selected compute stages,
// stream out, plus the per-region clock-gate enables.
module cg_seq_ctrl
  import cg_seq_pkg::*;
#(
  parameter int STAGE_CYC = STAGE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cg_en,
  input  logic                in_valid,
  input  logic [N_STAGES-1:0] in_mode,
  output logic                load_en,
  output logic [IDX_W-1:0]    wr_idx,
  output logic [N_STAGES-1:0] stage_en,
  output logic                stage_first,
  output logic [IDX_W-1:0]    rd_idx,
  output logic                out_valid,
  output logic                gclk_en_load,
  output logic [N_STAGES-1:0] gclk_en_calc,
  output logic                gclk_en_out,
  output logic                busy,
  output logic                err
);

  localparam logic [IDX_W-1:0] WORD_MAX  = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] STAGE_MAX = IDX_W'(STAGE_CYC - 1);

  state_t              state;
  logic [N_STAGES-1:0] mode_q;
  logic [IDX_W-1:0]    cur_stage;
  logic [IDX_W-1:0]    first_stage;
  logic [IDX_W-1:0]    nxt_stage;
  logic [IDX_W-1:0]    w_cnt;
  logic                w_tc;
  logic                w_clr;
  logic                w_load;
  logic                w_inc;
  logic [IDX_W-1:0]    s_cnt;
  logic                s_tc;
  logic                s_inc;
  logic                iv;
  logic                st_idle;
  logic                st_load;
  logic                st_calc;
  logic                st_out;
  logic                calc_last;

  assign st_idle = (state == IDLE);
  assign st_load = (state == LOAD);
  assign st_calc = (state == CALC);
  assign st_out  = (state == OUT);

  // Reset also masks in_valid so the reset cycle shows quiet enables.
  assign iv = in_valid & ~rst;

  assign first_stage = next_stage(mode_q, '0);
  assign nxt_stage   = next_stage(mode_q, cur_stage + IDX_W'(1));

  // Write and read phases never overlap, so one counter serves both indices.
  always_comb begin
    w_clr  = 1'b0;
    w_load = 1'b0;
    w_inc  = 1'b0;
    case (state)
      IDLE: w_load = in_valid;
      LOAD: begin
        if (in_valid && !w_tc) w_inc = 1'b1;
        else                   w_clr = 1'b1;
      end
      OUT: begin
        if (w_tc) w_clr = 1'b1;
        else      w_inc = 1'b1;
      end
      default: w_clr = 1'b1;
    endcase
  end

  cg_seq_cnt #(.MAX(WORD_MAX)) u_word_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .load    (w_load),
    .load_val(IDX_W'(1)),
    .inc     (w_inc),
    .count   (w_cnt),
    .tc      (w_tc)
  );

  assign s_inc = st_calc & ~s_tc;

  cg_seq_cnt #(.MAX(STAGE_MAX)) u_stage_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (~s_inc),
    .load    (1'b0),
    .load_val('0),
    .inc     (s_inc),
    .count   (s_cnt),
    .tc      (s_tc)
  );

  assign load_en     = iv & (st_idle | st_load);
  assign wr_idx      = st_load ? w_cnt : '0;
  assign rd_idx      = st_out ? w_cnt : '0;
  assign stage_first = st_calc & (s_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      cur_stage <= '0;
      stage_en  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= in_mode;
            state  <= LOAD;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (!in_valid) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (w_tc) begin
            if (mode_q == '0) begin
              state     <= OUT;
              out_valid <= 1'b1;
            end else begin
              state     <= CALC;
              cur_stage <= first_stage;
              stage_en  <= N_STAGES'(1) << first_stage[1:0];
            end
          end
        end
        CALC: begin
          err <= in_valid;
          if (s_tc) begin
            if (nxt_stage == STAGE_NONE) begin
              state     <= OUT;
              stage_en  <= '0;
              out_valid <= 1'b1;
            end else begin
              cur_stage <= nxt_stage;
              stage_en  <= N_STAGES'(1) << nxt_stage[1:0];
            end
          end
        end
        OUT: begin
          err <= in_valid;
          if (w_tc) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          stage_en  <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign calc_last = st_calc & s_tc & (nxt_stage == STAGE_NONE);

  // Enables open one cycle ahead of the bank that needs them; cg_en=0 forces all on.
  always_comb begin
    gclk_en_load = ~cg_en | (st_idle & iv) | st_load;
    gclk_en_out  = ~cg_en | calc_last | st_out | (st_load & w_tc & (mode_q == '0));
    for (int k = 0; k < N_STAGES; k++) begin
      gclk_en_calc[k] = ~cg_en | stage_en[k] | (st_load & w_tc & (first_stage == IDX_W'(k)));
    end
  end

endmodule

// File: tb/tb_cg_seq_ctrl.sv
// Directed bench for cg_seq_ctrl: reset, mode walks, gating override, protocol errors, burst streams.
module tb_cg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cg_en;
  logic       in_valid;
  logic [2:0] in_mode;
  logic       load_en;
  logic [2:0] wr_idx;
  logic [2:0] stage_en;
  logic       stage_first;
  logic [2:0] rd_idx;
  logic       out_valid;
  logic       gclk_en_load;
  logic [2:0] gclk_en_calc;
  logic       gclk_en_out;
  logic       busy;
  logic       err;

  cg_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cg_en       (cg_en),
    .in_valid    (in_valid),
    .in_mode     (in_mode),
    .load_en     (load_en),
    .wr_idx      (wr_idx),
    .stage_en    (stage_en),
    .stage_first (stage_first),
    .rd_idx      (rd_idx),
    .out_valid   (out_valid),
    .gclk_en_load(gclk_en_load),
    .gclk_en_calc(gclk_en_calc),
    .gclk_en_out (gclk_en_out),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic       ov_log   [40];
  logic [2:0] rd_log   [40];
  logic [2:0] se_log   [40];
  logic [2:0] wi_log   [40];
  logic [2:0] gc_log   [40];
  logic       sf_log   [40];
  logic       err_log  [40];
  logic       busy_log [40];
  logic       le_log   [40];
  logic       go_log   [40];
  int         ncyc;
  int         first_ov;
  int         ov_cnt;
  int         err_cnt;
  logic       gclk_all;
  logic [2:0] se_any;

  // One bench cycle: drive after the falling edge, observe 1 ns later.
  task automatic cyc(input logic v, input logic [2:0] m);
    @(negedge clk);
    in_valid = v;
    in_mode  = m;
    #1;
  endtask

  // Drive one burst (optionally truncated, with extra in_valid cycles) and log every cycle.
  task automatic do_burst(input logic [2:0] m, input int nwords, input logic [39:0] extra);
    first_ov = -1;
    ov_cnt   = 0;
    err_cnt  = 0;
    ncyc     = 0;
    gclk_all = 1'b1;
    se_any   = 3'b000;
    for (int c = 0; c < 40; c++) begin
      ov_log[c] = 0; rd_log[c] = 0; se_log[c] = 0; wi_log[c] = 0; gc_log[c] = 0;
      sf_log[c] = 0; err_log[c] = 0; busy_log[c] = 0; le_log[c] = 0; go_log[c] = 0;
    end
    for (int c = 0; c < 40; c++) begin
      cyc((c < nwords) | extra[c], m);
      ov_log[c]   = out_valid;
      rd_log[c]   = rd_idx;
      se_log[c]   = stage_en;
      wi_log[c]   = wr_idx;
      gc_log[c]   = gclk_en_calc;
      sf_log[c]   = stage_first;
      err_log[c]  = err;
      busy_log[c] = busy;
      le_log[c]   = load_en;
      go_log[c]   = gclk_en_out;
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = c;
      end
      if (err) err_cnt++;
      gclk_all = gclk_all & gclk_en_load & (&gclk_en_calc) & gclk_en_out;
      se_any   = se_any | stage_en;
      ncyc     = c + 1;
      if (c >= nwords && !busy) break;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("[TB] FAIL burst_timeout: busy=%0b after %0d cycles, required 0", busy, ncyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cg_en = 1'b1; in_valid = 1'b0; in_mode = 3'b000;
    #12;
    vectors++;
    if ({load_en, wr_idx, stage_en, stage_first, rd_idx, out_valid, busy, err} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, required 0",
               {load_en, wr_idx, stage_en, stage_first, rd_idx, out_valid, busy, err});
    end
    vectors++;
    if ({gclk_en_load, gclk_en_calc, gclk_en_out} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset_gclk_cg1: got %b, required 00000", {gclk_en_load, gclk_en_calc, gclk_en_out});
    end
    cg_en = 1'b0;
    #1;
    vectors++;
    if ({gclk_en_load, gclk_en_calc, gclk_en_out} !== 5'b11111) begin
      miscompares++;
      $display("[TB] FAIL reset_gclk_cg0: got %b, required 11111", {gclk_en_load, gclk_en_calc, gclk_en_out});
    end
    cg_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mid_load_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'b111);
    vectors++;
    if (wr_idx !== 3'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_load_state: wr_idx=%0d busy=%0b, required 3 and 1", wr_idx, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({load_en, wr_idx, stage_en, stage_first, rd_idx, out_valid, busy, err,
         gclk_en_load, gclk_en_calc, gclk_en_out} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_load_reset: got %h, required 0",
               {load_en, wr_idx, stage_en, stage_first, rd_idx, out_valid, busy, err,
                gclk_en_load, gclk_en_calc, gclk_en_out});
    end
    @(negedge clk);
    rst = 1'b0;
    do_burst(3'b000, 6, 40'd0);
    vectors++;
    if (first_ov !== 6 || ov_cnt !== 6) begin
      miscompares++;
      $display("[TB] FAIL after_reset_burst: first_ov=%0d count=%0d, required 6 and 6", first_ov, ov_cnt);
    end
  endtask

  task automatic test_mode000();
    do_burst(3'b000, 6, 40'd0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (wi_log[i] !== 3'(i) || le_log[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL m000_load[%0d]: wr_idx=%0d load_en=%0b, required %0d and 1", i, wi_log[i], le_log[i], i);
      end
    end
    vectors++;
    if (first_ov !== 6 || ov_cnt !== 6) begin
      miscompares++;
      $display("[TB] FAIL m000_latency: first_ov=%0d count=%0d, required 6 and 6", first_ov, ov_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rd_log[6 + i] !== 3'(i) || ov_log[6 + i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL m000_rd[%0d]: rd_idx=%0d out_valid=%0b, required %0d and 1", i, rd_log[6 + i], ov_log[6 + i], i);
      end
    end
    vectors++;
    if (ov_log[12] !== 1'b0 || rd_log[12] !== 3'd0 || ncyc !== 13) begin
      miscompares++;
      $display("[TB] FAIL m000_end: out_valid=%0b rd_idx=%0d ncyc=%0d, required 0 0 13", ov_log[12], rd_log[12], ncyc);
    end
    vectors++;
    if (se_any !== 3'b000 || err_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL m000_quiet: stage_en_or=%b errs=%0d, required 000 and 0", se_any, err_cnt);
    end
    vectors++;
    if (go_log[5] !== 1'b1 || gc_log[5] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL m000_gclk: out=%0b calc=%b at last word, required 1 and 000", go_log[5], gc_log[5]);
    end
  endtask

  task automatic test_mode101();
    logic [2:0] exp_se [4] = '{3'b001, 3'b001, 3'b100, 3'b100};
    logic       exp_sf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_burst(3'b101, 6, 40'd0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (se_log[6 + i] !== exp_se[i] || sf_log[6 + i] !== exp_sf[i]) begin
        miscompares++;
        $display("[TB] FAIL m101_stage[%0d]: stage_en=%b first=%0b, required %b and %0b",
                 i, se_log[6 + i], sf_log[6 + i], exp_se[i], exp_sf[i]);
      end
    end
    vectors++;
    if (first_ov !== 10 || ov_cnt !== 6) begin
      miscompares++;
      $display("[TB] FAIL m101_latency: first_ov=%0d count=%0d, required 10 and 6", first_ov, ov_cnt);
    end
    vectors++;
    if (gc_log[5] !== 3'b001 || gc_log[7] !== 3'b001 || gc_log[8] !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL m101_gclk_calc: c5=%b c7=%b c8=%b, required 001 001 100", gc_log[5], gc_log[7], gc_log[8]);
    end
    vectors++;
    if (go_log[8] !== 1'b0 || go_log[9] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL m101_gclk_out: c8=%0b c9=%0b, required 0 and 1", go_log[8], go_log[9]);
    end
  endtask

  task automatic test_cg_off();
    cg_en = 1'b0;
    do_burst(3'b101, 6, 40'd0);
    vectors++;
    if (gclk_all !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cg_off_gclk: all_enables=%0b, required 1", gclk_all);
    end
    vectors++;
    if (first_ov !== 10 || ov_cnt !== 6 || se_log[8] !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL cg_off_timing: first_ov=%0d count=%0d stage_c8=%b, required 10 6 100",
               first_ov, ov_cnt, se_log[8]);
    end
    cg_en = 1'b1;
  endtask

  task automatic test_drop();
    do_burst(3'b011, 3, 40'd0);
    vectors++;
    if (le_log[3] !== 1'b0 || wi_log[3] !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL drop_gap: load_en=%0b wr_idx=%0d, required 0 and 3", le_log[3], wi_log[3]);
    end
    vectors++;
    if (err_log[4] !== 1'b1 || err_cnt !== 1 || busy_log[4] !== 1'b0 || ncyc !== 5) begin
      miscompares++;
      $display("[TB] FAIL drop_err: err=%0b errs=%0d busy=%0b ncyc=%0d, required 1 1 0 5",
               err_log[4], err_cnt, busy_log[4], ncyc);
    end
    vectors++;
    if (ov_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL drop_no_output: out_valid cycles=%0d, required 0", ov_cnt);
    end
    do_burst(3'b011, 6, 40'd0);
    vectors++;
    if (first_ov !== 10 || ov_cnt !== 6 || se_log[6] !== 3'b001 || se_log[8] !== 3'b010 || se_log[9] !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL drop_recover: first_ov=%0d count=%0d se6=%b se8=%b se9=%b, required 10 6 001 010 010",
               first_ov, ov_cnt, se_log[6], se_log[8], se_log[9]);
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [39:0] extra;
    extra = '0;
    extra[6]  = 1'b1;
    extra[14] = 1'b1;
    do_burst(3'b111, 6, extra);
    vectors++;
    if (err_log[7] !== 1'b1 || err_log[15] !== 1'b1 || err_cnt !== 2) begin
      miscompares++;
      $display("[TB] FAIL ignore_err: c7=%0b c15=%0b errs=%0d, required 1 1 2", err_log[7], err_log[15], err_cnt);
    end
    vectors++;
    if (first_ov !== 12 || ov_cnt !== 6 || se_log[10] !== 3'b100 || rd_log[16] !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL ignore_seq: first_ov=%0d count=%0d se10=%b rd16=%0d, required 12 6 100 4",
               first_ov, ov_cnt, se_log[10], rd_log[16]);
    end
  endtask

  task automatic test_no_bubble();
    int guard;
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b000);
    for (int i = 0; i < 6; i++) cyc(1'b0, 3'b000);
    vectors++;
    if (out_valid !== 1'b1 || rd_idx !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL nobub_last_out: out_valid=%0b rd_idx=%0d, required 1 and 5", out_valid, rd_idx);
    end
    cyc(1'b1, 3'b010);
    vectors++;
    if (load_en !== 1'b1 || wr_idx !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nobub_accept: load_en=%0b wr_idx=%0d out_valid=%0b busy=%0b err=%0b, required 1 0 0 0 0",
               load_en, wr_idx, out_valid, busy, err);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'b010);
    cyc(1'b0, 3'b000);
    vectors++;
    if (stage_en !== 3'b010 || stage_first !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nobub_stage: stage_en=%b first=%0b, required 010 and 1", stage_en, stage_first);
    end
    guard = 0;
    while (busy && guard < 30) begin
      cyc(1'b0, 3'b000);
      guard++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nobub_drain: busy=%0b after %0d cycles, required 0", busy, guard);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] m;
    int         exp_ov;
    for (int n = 0; n < 1000; n++) begin
      m = 3'($urandom_range(0, 7));
      exp_ov = 6 + 2 * $countones(m);
      do_burst(m, 6, 40'd0);
      vectors++;
      if (first_ov !== exp_ov) begin
        miscompares++;
        $display("[TB] FAIL b2b_latency[%0d] mode=%b: first_ov=%0d, required %0d", n, m, first_ov, exp_ov);
      end
      vectors++;
      if (err_cnt !== 0 || ov_cnt !== 6) begin
        miscompares++;
        $display("[TB] FAIL b2b_stream[%0d] mode=%b: errs=%0d count=%0d, required 0 and 6", n, m, err_cnt, ov_cnt);
      end
      cyc(1'b0, 3'b000);
    end
  endtask

  initial begin
    $display("[TB] starting cg_seq_ctrl bench");
    test_reset();
    test_mid_load_reset();
    test_mode000();
    test_mode101();
    test_cg_off();
    test_drop();
    test_ignore_in_valid();
    test_no_bubble();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
